processor_multi_timer: RTL and testbench

Parametrised multi-channel interval timer on the processor's Avalon-MM bus. It generalises the single 32-bit interval timer to CHANNELS independent down-counters of configurable width. Each channel adds a per-channel clock prescaler, a per-channel IRQ line and lossless timeout flagging. A combined IRQ feeds the processor's interrupt controller.

---
 rtl/processor_multi_timer.sv | 159 +++++++++++++++
 tb/tb_processor_multi_timer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/processor_multi_timer.sv
`default_nettype none
// ============================================================================
// Module   : processor_multi_timer
// Brief    : Avalon-MM multi-channel interval timer with per-channel
//            prescaler, lossless timeout flag and per-channel IRQ lines.
// Revision : 1.0 - initial release
// ============================================================================
module processor_multi_timer #(
    parameter int CHANNELS       = 4,
    parameter int COUNTER_WIDTH  = 32,
    parameter int DEFAULT_PERIOD = 49999,
    parameter int ADDR_WIDTH     = $clog2(CHANNELS) + 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic                  irq,
    output logic [CHANNELS-1:0]   irq_vec
);

    localparam logic [COUNTER_WIDTH-1:0] c_DEFAULT = COUNTER_WIDTH'(DEFAULT_PERIOD);
    localparam logic [COUNTER_WIDTH-1:0] c_ONE     = COUNTER_WIDTH'(1);
    localparam logic [COUNTER_WIDTH-1:0] c_ZERO    = '0;

    localparam logic [1:0] c_REG_STATUS   = 2'd0;
    localparam logic [1:0] c_REG_CONTROL  = 2'd1;
    localparam logic [1:0] c_REG_PERIOD   = 2'd2;
    localparam logic [1:0] c_REG_SNAPSHOT = 2'd3;

    logic [31:0] w_chan;
    logic [1:0]  w_reg;
    logic        w_wr;
    logic [31:0] w_rd_next;
    logic        w_unused;

    logic [31:0] w_rd_status   [CHANNELS];
    logic [31:0] w_rd_control  [CHANNELS];
    logic [31:0] w_rd_period   [CHANNELS];
    logic [31:0] w_rd_snapshot [CHANNELS];

    assign w_chan   = 32'(address >> 2);
    assign w_reg    = address[1:0];
    assign w_wr     = chipselect & ~write_n;
    // Not every writedata bit is meaningful for every register or width.
    assign w_unused = ^writedata;

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
            logic [COUNTER_WIDTH-1:0] r_counter;
            logic [COUNTER_WIDTH-1:0] r_period;
            logic [COUNTER_WIDTH-1:0] r_snapshot;
            logic [7:0]               r_pre;
            logic [7:0]               r_pcnt;
            logic                     r_cont;
            logic                     r_ito;
            logic                     r_run;
            logic                     r_to;

            logic w_sel;
            logic w_tick;
            logic w_timeout;
            logic [COUNTER_WIDTH-1:0] w_new_period;

            assign w_sel        = w_wr && (w_chan == 32'(c));
            assign w_tick       = r_run && (r_pcnt == r_pre);
            assign w_timeout    = w_tick && (r_counter == c_ZERO);
            assign w_new_period = writedata[COUNTER_WIDTH-1:0];

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_counter  <= c_DEFAULT;
                    r_period   <= c_DEFAULT;
                    r_snapshot <= c_ZERO;
                    r_pre      <= 8'd0;
                    r_pcnt     <= 8'd0;
                    r_cont     <= 1'b0;
                    r_ito      <= 1'b0;
                    r_run      <= 1'b0;
                    r_to       <= 1'b0;
                end else begin
                    if (r_run) begin
                        r_pcnt <= w_tick ? 8'd0 : r_pcnt + 8'd1;
                    end
                    if (w_tick) begin
                        r_counter <= w_timeout ? r_period : r_counter - c_ONE;
                    end
                    // Clear precedes the timeout set so a coinciding event survives.
                    if (w_sel && (w_reg == c_REG_STATUS)) begin
                        r_to <= 1'b0;
                    end
                    if (w_timeout) begin
                        r_to <= 1'b1;
                        if (!r_cont) begin
                            r_run <= 1'b0;
                        end
                    end
                    if (w_sel && (w_reg == c_REG_CONTROL)) begin
                        r_cont <= writedata[1];
                        r_ito  <= writedata[0];
                        r_pre  <= writedata[15:8];
                        if (writedata[2]) begin
                            r_run  <= 1'b1;
                            r_pcnt <= 8'd0;
                        end else if (writedata[3]) begin
                            r_run <= 1'b0;
                        end
                    end
                    // A new period overrides any reload or decrement this cycle.
                    if (w_sel && (w_reg == c_REG_PERIOD)) begin
                        r_period  <= w_new_period;
                        r_counter <= w_new_period;
                        r_pcnt    <= 8'd0;
                        r_run     <= 1'b0;
                    end
                    if (w_sel && (w_reg == c_REG_SNAPSHOT)) begin
                        r_snapshot <= r_counter;
                    end
                end
            end

            assign w_rd_status[c]   = {30'd0, r_run, r_to};
            assign w_rd_control[c]  = {16'd0, r_pre, 6'd0, r_cont, r_ito};
            assign w_rd_period[c]   = 32'(r_period);
            assign w_rd_snapshot[c] = 32'(r_snapshot);
            assign irq_vec[c]       = r_to & r_ito;
        end
    endgenerate

    // Unmapped channel addresses match no channel and read as zero.
    always_comb begin
        w_rd_next = 32'd0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_chan == 32'(i)) begin
                case (w_reg)
                    c_REG_STATUS:   w_rd_next = w_rd_status[i];
                    c_REG_CONTROL:  w_rd_next = w_rd_control[i];
                    c_REG_PERIOD:   w_rd_next = w_rd_period[i];
                    default:        w_rd_next = w_rd_snapshot[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= 32'd0;
        end else begin
            readdata <= w_rd_next;
        end
    end

    assign irq = |irq_vec;

endmodule
`default_nettype wire

// File: tb/tb_processor_multi_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_processor_multi_timer
// Brief    : Self-checking bench for processor_multi_timer (3 x 16-bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_processor_multi_timer;

    localparam int NCH = 3;
    localparam int CW  = 16;
    localparam int AW  = 4;

    logic            clk;
    logic            reset;
    logic            chipselect;
    logic            write_n;
    logic [AW-1:0]   address;
    logic [31:0]     writedata;
    logic [31:0]     readdata;
    logic            irq;
    logic [NCH-1:0]  irq_vec;

    processor_multi_timer #(
        .CHANNELS      (NCH),
        .COUNTER_WIDTH (CW),
        .DEFAULT_PERIOD(49999),
        .ADDR_WIDTH    (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .chipselect(chipselect),
        .write_n   (write_n),
        .address   (address),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq),
        .irq_vec   (irq_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: one entry per channel.
    logic [CW-1:0] m_cnt  [NCH];
    logic [CW-1:0] m_per  [NCH];
    logic [CW-1:0] m_snap [NCH];
    logic [7:0]    m_pre  [NCH];
    logic [7:0]    m_pc   [NCH];
    bit            m_cont [NCH];
    bit            m_ito  [NCH];
    bit            m_run  [NCH];
    bit            m_to   [NCH];
    logic [31:0]   m_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_irqv();
        logic [31:0] v;
        v = 32'd0;
        for (int c = 0; c < NCH; c++) v[c] = m_to[c] & m_ito[c];
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_cnt[c] = 16'd49999; m_per[c] = 16'd49999; m_snap[c] = '0;
            m_pre[c] = '0; m_pc[c] = '0;
            m_cont[c] = 0; m_ito[c] = 0; m_run[c] = 0; m_to[c] = 0;
        end
        m_rd = 32'd0;
    endtask

    task automatic model_eval(input bit cs, input bit wn, input int addr, input logic [31:0] wd);
        int ch;
        int rg;
        bit wr;
        ch = addr / 4;
        rg = addr % 4;
        wr = cs && !wn && (ch < NCH);
        m_rd = 32'd0;
        if (ch < NCH) begin
            case (rg)
                0: m_rd = {30'd0, m_run[ch], m_to[ch]};
                1: m_rd = {16'd0, m_pre[ch], 6'd0, m_cont[ch], m_ito[ch]};
                2: m_rd = 32'(m_per[ch]);
                default: m_rd = 32'(m_snap[ch]);
            endcase
        end
        for (int c = 0; c < NCH; c++) begin
            bit tick;
            bit tmo;
            logic [CW-1:0] old_cnt;
            old_cnt = m_cnt[c];
            tick = m_run[c] && (m_pc[c] == m_pre[c]);
            tmo  = tick && (m_cnt[c] == 0);
            if (m_run[c]) m_pc[c] = tick ? 8'd0 : m_pc[c] + 8'd1;
            if (tmo) begin
                m_cnt[c] = m_per[c];
                m_to[c]  = 1;
                if (!m_cont[c]) m_run[c] = 0;
            end else if (tick) begin
                m_cnt[c] = m_cnt[c] - 16'd1;
            end
            if (wr && ch == c) begin
                case (rg)
                    0: m_to[c] = tmo;
                    1: begin
                        m_cont[c] = wd[1];
                        m_ito[c]  = wd[0];
                        m_pre[c]  = wd[15:8];
                        if (wd[2]) begin
                            m_run[c] = 1;
                            m_pc[c]  = 8'd0;
                        end else if (wd[3]) begin
                            m_run[c] = 0;
                        end
                    end
                    2: begin
                        m_per[c] = wd[CW-1:0];
                        m_cnt[c] = wd[CW-1:0];
                        m_pc[c]  = 8'd0;
                        m_run[c] = 0;
                    end
                    default: m_snap[c] = old_cnt;
                endcase
            end
        end
    endtask

    task automatic step(input bit cs, input bit wn, input int addr, input logic [31:0] wd);
        chipselect = cs;
        write_n    = wn;
        address    = AW'(addr);
        writedata  = wd;
        model_eval(cs, wn, addr, wd);
        @(posedge clk);
        #1;
        check("model_readdata", readdata, m_rd);
        check("model_irq_vec", 32'(irq_vec), model_irqv());
        check("model_irq", 32'(irq), 32'(|model_irqv()));
    endtask

    task automatic wr(input int addr, input logic [31:0] wd);
        step(1, 0, addr, wd);
    endtask

    task automatic rd(input int addr);
        step(1, 1, addr, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 32'd0);
    endtask

    task automatic reset_step();
        reset      = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check("reset_readdata", readdata, 32'd0);
        check("reset_irq", 32'(irq), 32'd0);
        check("reset_irq_vec", 32'(irq_vec), 32'd0);
        reset = 1'b0;
    endtask

    // Clocks from the current point until irq_vec[idx] rises, bounded by limit.
    task automatic wait_irq(input int idx, input int limit, output int n);
        n = 0;
        do begin
            step(0, 1, 0, 32'd0);
            n++;
        end while (!irq_vec[idx] && n < limit);
    endtask

    typedef struct {
        bit          is_wr;
        int          addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tbl[0]  = '{0, 2,  32'd0,          32'd49999};
        tbl[1]  = '{0, 0,  32'd0,          32'd0};
        tbl[2]  = '{0, 1,  32'd0,          32'd0};
        tbl[3]  = '{0, 3,  32'd0,          32'd0};
        tbl[4]  = '{0, 10, 32'd0,          32'd49999};
        tbl[5]  = '{1, 6,  32'h1234ABCD,   32'd49999};
        tbl[6]  = '{0, 6,  32'd0,          32'h0000ABCD};
        tbl[7]  = '{1, 14, 32'd5,          32'd0};
        tbl[8]  = '{0, 14, 32'd0,          32'd0};
        tbl[9]  = '{0, 12, 32'd0,          32'd0};
        tbl[10] = '{1, 15, 32'd0,          32'd0};
        tbl[11] = '{0, 13, 32'd0,          32'd0};

        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
        reset_step();
        reset_step();

        for (int i = 0; i < 12; i++) begin
            step(1, !tbl[i].is_wr, tbl[i].addr, tbl[i].wd);
            check("table_readdata", readdata, tbl[i].exp_rd);
            check("table_irq", 32'(irq), 32'd0);
        end

        // Continuous mode on channel 1.
        wr(6, 32'd9);
        wr(5, 32'h07);
        wait_irq(1, 40, n);
        check("cont_first_timeout_clocks", n, 10);
        wr(4, 32'd0);
        check("status_write_clears_irq", 32'(irq_vec[1]), 32'd0);
        wait_irq(1, 40, n);
        check("cont_second_timeout_clocks", n, 9);
        wr(4, 32'd0);
        check("status_clear_again", 32'(irq_vec[1]), 32'd0);
        idle(8);
        wr(4, 32'd0);
        check("status_write_vs_timeout", 32'(irq_vec[1]), 32'd1);
        wr(5, 32'h08);
        wr(4, 32'd0);

        // One-shot with prescaler on channel 2.
        wr(10, 32'd3);
        wr(9, 32'h0405);
        wait_irq(2, 60, n);
        check("oneshot_timeout_clocks", n, 20);
        rd(8);
        check("oneshot_status", readdata, 32'd1);
        wr(11, 32'd0);
        rd(11);
        check("oneshot_snapshot", readdata, 32'd3);

        // PERIOD write while channel 0 counts.
        wr(1, 32'h05);
        idle(30);
        wr(2, 32'd100);
        rd(0);
        check("period_write_stops", readdata, 32'd0);
        wr(3, 32'd0);
        rd(3);
        check("period_write_loads", readdata, 32'd100);
        wr(1, 32'h05);
        wait_irq(0, 200, n);
        check("period_timeout_clocks", n, 101);

        // START/STOP priority and hold.
        wr(0, 32'd0);
        wr(1, 32'h07);
        idle(5);
        wr(1, 32'h0C);
        rd(0);
        check("start_beats_stop", readdata, 32'd2);
        wr(1, 32'h08);
        rd(0);
        check("stop_clears_run", readdata, 32'd0);
        wr(3, 32'd0);
        rd(3);
        check("hold_snapshot_a", readdata, 32'd92);
        idle(50);
        wr(3, 32'd0);
        rd(3);
        check("hold_snapshot_b", readdata, 32'd92);

        // All three channels time out together.
        wr(2, 32'd7);
        wr(6, 32'd6);
        wr(10, 32'd5);
        wr(0, 32'd0);
        wr(4, 32'd0);
        wr(8, 32'd0);
        wr(1, 32'h07);
        wr(5, 32'h07);
        wr(9, 32'h07);
        n = 0;
        do begin
            idle(1);
            n++;
        end while (irq_vec == '0 && n < 20);
        check("simultaneous_irq_vec", 32'(irq_vec), 32'd7);
        check("simultaneous_clocks", n, 6);
        wr(1, 32'h08);
        wr(5, 32'h08);
        wr(9, 32'h08);

        // Randomized bus traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            int a;
            logic [31:0] d;
            bit cs;
            bit wn;
            a  = int'($urandom_range(0, 15));
            d  = $urandom;
            cs = ($urandom_range(0, 1) == 1);
            wn = ($urandom_range(0, 3) != 0);
            if (a % 4 == 2) d[15:0] = 16'($urandom_range(0, 12));
            if (a % 4 == 1) d[15:8] = 8'($urandom_range(0, 2));
            step(cs, wn, a, d);
        end

        // Reset one clock before a pending timeout.
        wr(6, 32'd2);
        wr(5, 32'h07);
        idle(2);
        reset_step();
        rd(4);
        check("reset_abort_status", readdata, 32'd0);
        check("reset_abort_irq", 32'(irq), 32'd0);
        rd(2);
        check("reset_abort_period", readdata, 32'd49999);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
